abaud_detect: RTL and testbench
===============================

ABAUD_DETECT -- requirements
Module: abaud_detect

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the measurement counter and BRG width (CNT_W >= DIV_SHIFT+2).
REQ-002 The module SHALL have parameter FALLS, default 4, giving the number of falling edges after the start edge that close a measurement (1..15).
REQ-003 The module SHALL have parameter DIV_SHIFT, default 3, giving the log2 divisor applied to the measured count (0..CNT_W-2).
REQ-004 The module SHALL have parameter SYNC_STAGES, default 2, giving the UXRX synchronizer depth (>= 2).
REQ-005 The module SHALL have the following ports:
- CLK  input  1  the single clock; all state changes on its rising edge.
- RST  input  1  reset, asynchronous, active-high.
- UXRX  input  1  asynchronous serial line, idle high.
- ABAUD  input  1  level request; high arms detection, low aborts or re-enables.
- OVF_CLR  input  1  one-cycle clear of ABDOVF.
- BRG  output  CNT_W  last successful baud divisor.
- UXRXIF  output  1  one-cycle completion pulse.
- BUSY  output  1  high while a detection is armed or running.
- ABDOVF  output  1  sticky counter-overflow flag.

Function
REQ-006 UXRX SHALL pass through SYNC_STAGES flops (reset value 1); the falling edge SHALL be detected as current synced value 0 and previous synced value 1.
REQ-007 The FSM SHALL have six states: IDLE, ARM, WAIT_START, MEASURE, DONE and HOLD.
REQ-008 In IDLE, ABAUD=1 SHALL move to ARM; otherwise the FSM stays in IDLE.
REQ-009 ARM SHALL wait for synced UXRX=1, then move to WAIT_START, so that a line already low is not taken as a start edge.
REQ-010 In WAIT_START, a detected fall SHALL clear the cycle counter to 0, clear the fall counter to 0, and move to MEASURE.
REQ-011 In MEASURE, the cycle counter SHALL increment by 1 every cycle.
REQ-012 In MEASURE, each detected fall SHALL increment the fall counter.
REQ-013 In MEASURE, the fall that brings the fall counter to FALLS SHALL:
- capture C = cycle counter + 1;
- load BRG = (C + 2^(DIV_SHIFT-1)) >> DIV_SHIFT, computed in CNT_W+1 bits, or BRG = C when DIV_SHIFT = 0;
- move to DONE.
REQ-014 With FALLS=4 and a 0x55 character, C SHALL equal 8 bit times, so BRG equals clocks per bit when DIV_SHIFT=3.
REQ-015 Synchronizer latency SHALL be identical for every edge and SHALL NOT bias C.
REQ-016 If the cycle counter equals all-ones in MEASURE without the final fall, the FSM SHALL set ABDOVF, leave BRG unchanged, raise no UXRXIF, and move to HOLD.
REQ-017 A final fall coinciding with the all-ones count SHALL take the overflow path.
REQ-018 DONE SHALL last exactly one cycle with UXRXIF=1, then move to HOLD; the new BRG SHALL already be visible during that cycle.
REQ-019 HOLD SHALL remain until ABAUD=0, then move to IDLE; a level-high ABAUD SHALL never start a second measurement.
REQ-020 ABAUD=0 in ARM, WAIT_START or MEASURE SHALL abort to IDLE with BRG, ABDOVF and UXRXIF unaffected.
REQ-021 BUSY SHALL be 1 exactly in ARM, WAIT_START and MEASURE.
REQ-022 UXRXIF SHALL be 1 only in DONE.
REQ-023 OVF_CLR=1 SHALL clear ABDOVF on the next edge; if set and clear occur in the same cycle, set SHALL win.
REQ-024 BRG SHALL change only in the MEASURE-to-DONE transition and on reset.

Reset
REQ-025 RST=1 SHALL immediately force, without waiting for CLK:
- the FSM to IDLE;
- BRG=0, UXRXIF=0, BUSY=0 and ABDOVF=0;
- both counters to 0;
- the synchronizer flops to 1.
REQ-026 RST asserted mid-measurement SHALL discard the measurement, and normal operation SHALL resume on the first CLK edge after release.

Verification
REQ-027 The bench SHALL cover the nominal case: defaults, ABAUD=1, 0x55 at 104 clocks/bit -> one-cycle UXRXIF, BRG=104, BUSY low after DONE.
REQ-028 The bench SHALL cover rounding: start-to-4th-fall spacing totalling 835 clocks -> BRG=(835+4)>>3=104; a total of 831 -> BRG=104; a total of 827 -> BRG=103.
REQ-029 The bench SHALL cover overflow: CNT_W=8, 40 clocks/bit -> ABDOVF=1, BRG unchanged, no UXRXIF, FSM in HOLD; then OVF_CLR pulse -> ABDOVF=0.
REQ-030 The bench SHALL cover abort: ABAUD dropped after 2 falls -> IDLE, BUSY=0, BRG keeps its prior value; then ABAUD=1 with the line held low -> stays in ARM, no spurious start.
REQ-031 The bench SHALL cover hold: after DONE, ABAUD kept high and a second 0x55 sent -> no new UXRXIF and BRG unchanged; ABAUD 0 then 1 followed by 0x55 at 52 clocks/bit -> BRG=52.
REQ-032 The bench SHALL cover reset: RST pulsed mid-MEASURE between clock edges -> all outputs 0 immediately; a fresh 0x55 after release at 104 clocks/bit -> BRG=104.

Source files
------------

// File: rtl/abaud_detect.sv
// abaud_detect: auto-baud detector that times a 0x55 character and loads a baud divisor.
// Ports:
//   CLK     - single clock, rising edge
//   RST     - asynchronous active-high reset
//   UXRX    - asynchronous serial line, idle high
//   ABAUD   - level request: high arms detection, low aborts / re-enables
//   OVF_CLR - one-cycle clear of ABDOVF
//   BRG     - last successful baud divisor
//   UXRXIF  - one-cycle completion pulse
//   BUSY    - high while a detection is armed or running
//   ABDOVF  - sticky measurement-counter overflow flag
module abaud_detect #(
    parameter int CNT_W       = 16,
    parameter int FALLS       = 4,
    parameter int DIV_SHIFT   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UXRX,
    input  logic             ABAUD,
    input  logic             OVF_CLR,
    output logic [CNT_W-1:0] BRG,
    output logic             UXRXIF,
    output logic             BUSY,
    output logic             ABDOVF
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_START,
        S_MEASURE,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic [3:0] LP_FALLS = 4'(FALLS);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [3:0]             r_falls;
    logic                   w_rx;
    logic                   w_fall;
    logic                   w_full;
    logic                   w_last_fall;
    logic                   w_start;
    logic                   w_load;
    logic                   w_ovf;
    logic [CNT_W-1:0]       w_brg;

    // Every edge sees the same synchronizer delay, so fall-to-fall spacing is exact.
    assign w_rx        = r_sync[SYNC_STAGES-1];
    assign w_fall      = !w_rx && r_prev;
    assign w_full      = &r_cnt;
    assign w_last_fall = w_fall && (r_falls + 4'd1 == LP_FALLS);

    // C = r_cnt + 1 is the start-to-final-fall spacing; round it to nearest on the divide.
    if (DIV_SHIFT == 0) begin : g_nodiv
        assign w_brg = r_cnt + CNT_W'(1);
    end else begin : g_div
        localparam logic [CNT_W:0] LP_HALF = (CNT_W+1)'(2 ** (DIV_SHIFT - 1));
        logic [CNT_W:0] w_sum;
        assign w_sum = {1'b0, r_cnt} + (CNT_W+1)'(1) + LP_HALF;
        assign w_brg = CNT_W'(w_sum >> DIV_SHIFT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], UXRX};
            r_prev <= w_rx;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Abort takes priority, then overflow (so a final fall on the all-ones count overflows).
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ABAUD) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (!ABAUD)    w_state_nxt = S_IDLE;
                else if (w_rx) w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!ABAUD) w_state_nxt = S_IDLE;
                else if (w_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!ABAUD) w_state_nxt = S_IDLE;
                else if (w_full) begin
                    w_ovf       = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (w_last_fall) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (!ABAUD) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        BUSY   = (r_state == S_ARM) || (r_state == S_WAIT_START) || (r_state == S_MEASURE);
        UXRXIF = (r_state == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_falls <= '0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_falls <= '0;
        end else if (r_state == S_MEASURE) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_falls <= w_fall ? r_falls + 4'd1 : r_falls;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BRG    <= '0;
            ABDOVF <= 1'b0;
        end else begin
            if (w_load) BRG <= w_brg;
            ABDOVF <= w_ovf ? 1'b1 : (OVF_CLR ? 1'b0 : ABDOVF);
        end
    end
endmodule

// File: tb/tb_abaud_detect.sv
// tb_abaud_detect: directed self-checking bench for abaud_detect.
`timescale 1ns/1ps
module tb_abaud_detect;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uxrx = 1'b1, abaud = 1'b0, ovf_clr = 1'b0;
    logic [15:0] brg;
    logic        uxrxif, busy, abdovf;
    logic        uxrx_o = 1'b1, abaud_o = 1'b0, ovf_clr_o = 1'b0;
    logic [7:0]  brg_o;
    logic        uxrxif_o, busy_o, abdovf_o;
    int          n_pass = 0, n_total = 0;
    int          if_cnt = 0, if_cnt_o = 0;
    logic [15:0] brg_at_if = '0;

    abaud_detect dut (
        .CLK(clk), .RST(rst), .UXRX(uxrx), .ABAUD(abaud), .OVF_CLR(ovf_clr),
        .BRG(brg), .UXRXIF(uxrxif), .BUSY(busy), .ABDOVF(abdovf)
    );

    abaud_detect #(.CNT_W(8)) dut_o (
        .CLK(clk), .RST(rst), .UXRX(uxrx_o), .ABAUD(abaud_o), .OVF_CLR(ovf_clr_o),
        .BRG(brg_o), .UXRXIF(uxrxif_o), .BUSY(busy_o), .ABDOVF(abdovf_o)
    );

    always #5 clk = ~clk;

    // Pulse counters: a one-cycle UXRXIF adds exactly one; BRG is captured while UXRXIF is high.
    always @(posedge clk) begin
        if (uxrxif === 1'b1) begin
            if_cnt    <= if_cnt + 1;
            brg_at_if <= brg;
        end
        if (uxrxif_o === 1'b1) if_cnt_o <= if_cnt_o + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input bit o, input logic v);
        if (o) uxrx_o = v;
        else   uxrx   = v;
    endtask

    task automatic send_byte(input bit o, input logic [7:0] b, input int t);
        set_line(o, 1'b0);
        wait_cyc(t);
        for (int i = 0; i < 8; i++) begin
            set_line(o, b[i]);
            wait_cyc(t);
        end
        set_line(o, 1'b1);
        wait_cyc(t + 10);
    endtask

    // Start fall followed by four falls at the given spacings.
    task automatic send_falls(input int d0, input int d1, input int d2, input int d3);
        int d[4];
        d = '{d0, d1, d2, d3};
        uxrx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(d[i] / 2);
            uxrx = 1'b1;
            wait_cyc(d[i] - d[i] / 2);
            uxrx = 1'b0;
        end
        wait_cyc(50);
        uxrx = 1'b1;
        wait_cyc(20);
    endtask

    task automatic rearm();
        abaud = 1'b0;
        wait_cyc(5);
        abaud = 1'b1;
        wait_cyc(10);
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (brg !== 16'd0) $display("FAIL reset_brg: got %0d want 0", brg); else n_pass++;
        n_total++; if (uxrxif !== 1'b0) $display("FAIL reset_uxrxif: got %b want 0", uxrxif); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (abdovf !== 1'b0) $display("FAIL reset_abdovf: got %b want 0", abdovf); else n_pass++;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_nominal();
        int c0;
        abaud = 1'b1;
        wait_cyc(10);
        n_total++; if (busy !== 1'b1) $display("FAIL armed_busy: got %b want 1", busy); else n_pass++;
        c0 = if_cnt;
        send_byte(1'b0, 8'h55, 104);
        n_total++; if (if_cnt - c0 !== 1) $display("FAIL nominal_if: got %0d pulses want 1", if_cnt - c0); else n_pass++;
        n_total++; if (brg_at_if !== 16'd104) $display("FAIL nominal_brg_in_done: got %0d want 104", brg_at_if); else n_pass++;
        n_total++; if (brg !== 16'd104) $display("FAIL nominal_brg: got %0d want 104", brg); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL nominal_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_rounding();
        int c0;
        rearm();
        c0 = if_cnt;
        send_falls(209, 209, 209, 208);
        n_total++; if (brg !== 16'd104) $display("FAIL round_835: got %0d want 104", brg); else n_pass++;
        n_total++; if (if_cnt - c0 !== 1) $display("FAIL round_835_if: got %0d want 1", if_cnt - c0); else n_pass++;
        rearm();
        send_falls(208, 208, 208, 207);
        n_total++; if (brg !== 16'd104) $display("FAIL round_831: got %0d want 104", brg); else n_pass++;
        rearm();
        send_falls(207, 207, 207, 206);
        n_total++; if (brg !== 16'd103) $display("FAIL round_827: got %0d want 103", brg); else n_pass++;
    endtask

    task automatic test_abort();
        int c0;
        rearm();
        c0 = if_cnt;
        uxrx = 1'b0; wait_cyc(50);
        uxrx = 1'b1; wait_cyc(50);
        uxrx = 1'b0; wait_cyc(50);
        uxrx = 1'b1; wait_cyc(50);
        uxrx = 1'b0; wait_cyc(20);
        abaud = 1'b0;
        wait_cyc(3);
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (brg !== 16'd103) $display("FAIL abort_brg: got %0d want 103", brg); else n_pass++;
        n_total++; if (if_cnt !== c0) $display("FAIL abort_if: got %0d pulses want 0", if_cnt - c0); else n_pass++;
        wait_cyc(10);
        abaud = 1'b1;
        wait_cyc(50);
        n_total++; if (busy !== 1'b1) $display("FAIL arm_low_busy: got %b want 1", busy); else n_pass++;
        n_total++; if (if_cnt !== c0) $display("FAIL arm_low_if: got %0d pulses want 0", if_cnt - c0); else n_pass++;
        uxrx = 1'b1;
        wait_cyc(10);
        send_byte(1'b0, 8'h55, 60);
        n_total++; if (brg !== 16'd60) $display("FAIL after_abort_brg: got %0d want 60", brg); else n_pass++;
        n_total++; if (if_cnt - c0 !== 1) $display("FAIL after_abort_if: got %0d want 1", if_cnt - c0); else n_pass++;
    endtask

    task automatic test_hold();
        int c0;
        c0 = if_cnt;
        send_byte(1'b0, 8'h55, 80);
        n_total++; if (if_cnt !== c0) $display("FAIL hold_if: got %0d pulses want 0", if_cnt - c0); else n_pass++;
        n_total++; if (brg !== 16'd60) $display("FAIL hold_brg: got %0d want 60", brg); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL hold_busy: got %b want 0", busy); else n_pass++;
        rearm();
        send_byte(1'b0, 8'h55, 52);
        n_total++; if (brg !== 16'd52) $display("FAIL rearm_brg: got %0d want 52", brg); else n_pass++;
        n_total++; if (if_cnt - c0 !== 1) $display("FAIL rearm_if: got %0d want 1", if_cnt - c0); else n_pass++;
    endtask

    task automatic test_overflow();
        abaud_o = 1'b1;
        wait_cyc(10);
        send_byte(1'b1, 8'h55, 40);
        n_total++; if (abdovf_o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", abdovf_o); else n_pass++;
        n_total++; if (brg_o !== 8'd0) $display("FAIL ovf_brg: got %0d want 0", brg_o); else n_pass++;
        n_total++; if (if_cnt_o !== 0) $display("FAIL ovf_if: got %0d pulses want 0", if_cnt_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL ovf_hold_busy: got %b want 0", busy_o); else n_pass++;
        wait_cyc(5);
        n_total++; if (abdovf_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", abdovf_o); else n_pass++;
        ovf_clr_o = 1'b1;
        wait_cyc(1);
        ovf_clr_o = 1'b0;
        wait_cyc(1);
        n_total++; if (abdovf_o !== 1'b0) $display("FAIL ovf_clear: got %b want 0", abdovf_o); else n_pass++;
        abaud_o = 1'b0;
        wait_cyc(3);
    endtask

    task automatic test_mid_reset();
        int c0;
        rearm();
        uxrx = 1'b0; wait_cyc(104);
        uxrx = 1'b1; wait_cyc(104);
        uxrx = 1'b0; wait_cyc(50);
        n_total++; if (busy !== 1'b1) $display("FAIL measure_busy: got %b want 1", busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (brg !== 16'd0) $display("FAIL midrst_brg: got %0d want 0", brg); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (uxrxif !== 1'b0) $display("FAIL midrst_uxrxif: got %b want 0", uxrxif); else n_pass++;
        n_total++; if (abdovf !== 1'b0) $display("FAIL midrst_abdovf: got %b want 0", abdovf); else n_pass++;
        uxrx = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        c0 = if_cnt;
        send_byte(1'b0, 8'h55, 104);
        n_total++; if (brg !== 16'd104) $display("FAIL postrst_brg: got %0d want 104", brg); else n_pass++;
        n_total++; if (if_cnt - c0 !== 1) $display("FAIL postrst_if: got %0d want 1", if_cnt - c0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rounding();
        test_abort();
        test_hold();
        test_overflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
